// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer: ramps a PWM duty word toward a commanded target at a prescaled
// tick rate, dwells there for a programmable number of ticks, then pulses done.
module pwm_fade_sequencer #(
    parameter int DW = 8,
    parameter int HW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_target,
    input  logic [3:0]    cmd_step,
    input  logic [HW-1:0] cmd_hold,
    input  logic [PW-1:0] tick_div,
    input  logic          abort,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [DW-1:0] duty_r, duty_s;
    logic          done_r, done_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [DW-1:0] tgt_r, tgt_s;
    logic [3:0]    step_r, step_s;
    logic [HW-1:0] hold_r, hold_s;
    logic          tick_s;
    logic [DW-1:0] ramp_duty_s;

    // One ramp increment toward tgt; compares in DW+1 bits so it can neither
    // overshoot nor wrap. A step of zero moves by one.
    function automatic logic [DW-1:0] ramp_next(
        input logic [DW-1:0] cur,
        input logic [DW-1:0] tgt,
        input logic [3:0]    step
    );
        logic [DW:0]   cur_x;
        logic [DW:0]   tgt_x;
        logic [DW:0]   stp_x;
        logic [DW-1:0] res;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        stp_x = {{(DW-3){1'b0}}, ((step == 4'd0) ? 4'd1 : step)};
        if (tgt_x > cur_x) begin
            if ((tgt_x - cur_x) <= stp_x) begin
                res = tgt;
            end else begin
                res = cur + stp_x[DW-1:0];
            end
        end else if (cur_x > tgt_x) begin
            if ((cur_x - tgt_x) <= stp_x) begin
                res = tgt;
            end else begin
                res = cur - stp_x[DW-1:0];
            end
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    assign tick_s      = (presc_r == tick_div);
    assign ramp_duty_s = ramp_next(duty_r, tgt_r, step_r);
    assign cmd_ready   = (state_r == IDLE) & ena & ~abort;
    assign busy        = (state_r != IDLE);
    assign duty        = duty_r;
    assign done        = done_r;

    // Next-state, datapath and done decode; ena low freezes everything.
    always_comb begin
        state_s    = state_r;
        duty_s     = duty_r;
        done_s     = 1'b0;
        presc_s    = presc_r;
        hold_cnt_s = hold_cnt_r;
        tgt_s      = tgt_r;
        step_s     = step_r;
        hold_s     = hold_r;
        if (ena) begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && !abort) begin
                        tgt_s      = cmd_target;
                        step_s     = cmd_step;
                        hold_s     = cmd_hold;
                        presc_s    = {PW{1'b0}};
                        hold_cnt_s = {HW{1'b0}};
                        state_s    = RAMP;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state_s = IDLE;
                    end else if (tick_s) begin
                        presc_s = {PW{1'b0}};
                        duty_s  = ramp_duty_s;
                        if (ramp_duty_s == tgt_r) begin
                            state_s    = HOLD;
                            hold_cnt_s = {HW{1'b0}};
                        end else begin
                            state_s = RAMP;
                        end
                    end else begin
                        presc_s = presc_r + PW'(1);
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_s = IDLE;
                    end else if (tick_s) begin
                        presc_s = {PW{1'b0}};
                        if (hold_cnt_r == hold_r) begin
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HW'(1);
                        end
                    end else begin
                        presc_s = presc_r + PW'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= IDLE;
            duty_r     <= {DW{1'b0}};
            done_r     <= 1'b0;
            presc_r    <= {PW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            tgt_r      <= {DW{1'b0}};
            step_r     <= 4'd0;
            hold_r     <= {HW{1'b0}};
        end else begin
            state_r    <= state_s;
            duty_r     <= duty_s;
            done_r     <= done_s;
            presc_r    <= presc_s;
            hold_cnt_r <= hold_cnt_s;
            tgt_r      <= tgt_s;
            step_r     <= step_s;
            hold_r     <= hold_s;
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: cycle reference model feeding a scoreboard queue,
// plus directed checks of the documented fade scenarios.
module tb_pwm_fade_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_target;
    logic [3:0]  cmd_step;
    logic [7:0]  cmd_hold;
    logic [15:0] tick_div;
    logic        abort;
    logic [7:0]  duty;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int m_state, m_duty, m_done, m_presc, m_hcnt, m_tgt, m_step, m_hold;
    logic [9:0] sb_q[$];
    logic       prev_done = 1'b0;
    logic [7:0] d_log[1:16];
    logic       dn_log[1:16];
    logic       bz_log[1:16];
    int         done_cnt;

    pwm_fade_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_target(cmd_target), .cmd_step(cmd_step),
        .cmd_hold(cmd_hold), .tick_div(tick_div), .abort(abort),
        .duty(duty), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs now applied.
    task automatic model_clk();
        int  s;
        bit  tick;
        if (rst_n) begin
            m_state = 0; m_duty = 0; m_done = 0; m_presc = 0;
            m_hcnt = 0; m_tgt = 0; m_step = 0; m_hold = 0;
        end else if (!ena) begin
            m_done = 0;
        end else begin
            m_done = 0;
            tick = (m_presc == int'(tick_div));
            case (m_state)
                0: if (cmd_valid && !abort) begin
                    m_tgt = cmd_target; m_step = cmd_step; m_hold = cmd_hold;
                    m_presc = 0; m_hcnt = 0; m_state = 1;
                end
                1: if (abort) m_state = 0;
                   else if (tick) begin
                       m_presc = 0;
                       s = (m_step == 0) ? 1 : m_step;
                       if (m_tgt > m_duty) m_duty = (m_tgt - m_duty <= s) ? m_tgt : m_duty + s;
                       else if (m_tgt < m_duty) m_duty = (m_duty - m_tgt <= s) ? m_tgt : m_duty - s;
                       if (m_duty == m_tgt) begin m_state = 2; m_hcnt = 0; end
                   end else m_presc = (m_presc + 1) & 16'hFFFF;
                2: if (abort) m_state = 0;
                   else if (tick) begin
                       m_presc = 0;
                       if (m_hcnt == m_hold) begin m_done = 1; m_state = 0; end
                       else m_hcnt = (m_hcnt + 1) & 8'hFF;
                   end else m_presc = (m_presc + 1) & 16'hFFFF;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: check cmd_ready, push the model's expectation, compare after the edge.
    task automatic step();
        logic [9:0] e;
        logic       exp_rdy;
        #1;
        exp_rdy = (m_state == 0) && ena && !abort;
        chk("cmd_ready", cmd_ready, exp_rdy);
        model_clk();
        sb_q.push_back({m_duty[7:0], m_done[0], (m_state != 0)});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("duty", duty, e[9:2]);
        chk("done", done, e[1]);
        chk("busy", busy, e[0]);
        if (done) chk("done_pair", prev_done, 1'b0);
        prev_done = done;
    endtask

    task automatic send(input logic [7:0] tgt, input logic [3:0] stp, input logic [7:0] hld);
        cmd_target = tgt; cmd_step = stp; cmd_hold = hld; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        step();
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_target = 8'd0;
        cmd_step = 4'd0; cmd_hold = 8'd0; tick_div = 16'd0; abort = 1'b0;
        @(posedge clk);
        #1;
        model_clk();
        step();
        chk("rst_duty", duty, 8'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1'b1);

        // Up-ramp 0 -> 10 by 4, hold 0
        send(8'd10, 4'd4, 8'd0);
        chk("up_acc", duty, 8'd0);
        step(); chk("up_d1", duty, 8'd4);
        step(); chk("up_d2", duty, 8'd8);
        step(); chk("up_d3", duty, 8'd10);
        chk("up_done0", done, 1'b0);
        step(); chk("up_done", done, 1'b1);
        step(); chk("up_done_clr", done, 1'b0);
        #1; chk("up_ready", cmd_ready, 1'b1);

        // Down-ramp 200 -> 190 by 7, prescaler 2, hold 2
        send(8'd200, 4'd15, 8'd0);
        wait_idle(60);
        chk("pre_200", duty, 8'd200);
        tick_div = 16'd2;
        send(8'd190, 4'd7, 8'd2);
        done_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            d_log[i] = duty; dn_log[i] = done; bz_log[i] = busy;
            if (done) done_cnt++;
        end
        chk("dn_d2", d_log[2], 8'd200);
        chk("dn_d3", d_log[3], 8'd193);
        chk("dn_d5", d_log[5], 8'd193);
        chk("dn_d6", d_log[6], 8'd190);
        chk("dn_busy14", bz_log[14], 1'b1);
        chk("dn_done14", dn_log[14], 1'b0);
        chk("dn_done15", dn_log[15], 1'b1);
        chk("dn_busy15", bz_log[15], 1'b0);
        chk("dn_done_cnt", done_cnt, 1);

        // Saturation at 255, then zero step acting as one
        tick_div = 16'd0;
        send(8'd250, 4'd15, 8'd0);
        wait_idle(20);
        send(8'd255, 4'd15, 8'd0);
        step(); chk("sat_255", duty, 8'd255);
        wait_idle(10);
        send(8'd252, 4'd0, 8'd0);
        step(); chk("z_254", duty, 8'd254);
        step(); chk("z_253", duty, 8'd253);
        step(); chk("z_252", duty, 8'd252);
        wait_idle(10);

        // Abort in RAMP at duty 8
        send(8'd0, 4'd15, 8'd0);
        wait_idle(40);
        send(8'd20, 4'd4, 8'd0);
        step(); step(); chk("ab_d8", duty, 8'd8);
        abort = 1'b1;
        step(); chk("ab_idle", busy, 1'b0); chk("ab_duty", duty, 8'd8);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("ab_nodone", done, 1'b0);
        end
        // Abort together with cmd_valid in IDLE
        abort = 1'b1;
        send(8'd100, 4'd1, 8'd0);
        chk("ab_noacc", busy, 1'b0);
        abort = 1'b0;

        // ena low for 5 cycles mid-ramp
        send(8'd40, 4'd4, 8'd5);
        step(); step(); chk("en_d16", duty, 8'd16);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); chk("en_frz", duty, 8'd16); chk("en_busy", busy, 1'b1);
        end
        ena = 1'b1;
        step(); chk("en_resume", duty, 8'd20);
        for (int i = 0; i < 6; i++) step();
        chk("en_at40", duty, 8'd40);
        // Reset while in HOLD
        rst_n = 1'b1;
        step(); chk("hr_duty", duty, 8'd0); chk("hr_busy", busy, 1'b0); chk("hr_done", done, 1'b0);
        rst_n = 1'b0;
        #1; chk("hr_ready", cmd_ready, 1'b1);

        // Same-target command
        send(8'd0, 4'd3, 8'd0);
        step(); chk("st_d1", duty, 8'd0); chk("st_done1", done, 1'b0);
        step(); chk("st_done2", done, 1'b1); chk("st_d2", duty, 8'd0);

        // Random traffic against the model; tick_div only rises while busy
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            abort     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_target = 8'($urandom_range(0, 255));
            cmd_step  = 4'($urandom_range(0, 15));
            cmd_hold  = 8'($urandom_range(0, 3));
            if (m_state == 0) tick_div = 16'($urandom_range(0, 2));
            else if ($urandom_range(0, 15) == 0 && tick_div < 16'd4) tick_div = tick_div + 16'd1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- DW, 8, duty word width
- HW, 8, hold-count width
- PW, 16, prescaler width
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock for all state
- rst_n, in, 1, reset; synchronous, active-high (asserted = 1)
- ena, in, 1, design enable; low freezes all state
- cmd_valid, in, 1, fade command offered
- cmd_ready, out, 1, fade command can be accepted
- cmd_target, in, DW, final duty value
- cmd_step, in, 4, duty change per tick
- cmd_hold, in, HW, ticks to dwell at target
- tick_div, in, PW, prescaler terminal count
- abort, in, 1, cancel active fade
- duty, out, DW, duty word driving the PWM core
- busy, out, 1, state != IDLE
- done, out, 1, one-cycle completion pulse

Function
REQ-003 SHALL implement FSM states IDLE, RAMP, HOLD; all outputs registered except cmd_ready and busy, which decode state.
REQ-004 SHALL drive cmd_ready = (state==IDLE) & ena & !abort; a command is accepted on a clk edge with cmd_valid & cmd_ready.
REQ-005 On acceptance SHALL latch target, step, hold; clear prescaler and hold counter; go IDLE->RAMP. duty SHALL be unchanged on acceptance; a new fade starts from the current duty.
REQ-006 SHALL treat a latched step of 0 as 1.
REQ-007 Prescaler SHALL count 0..tick_div while in RAMP/HOLD with ena=1. tick SHALL be asserted when the count equals tick_div, and the count SHALL then wrap to 0. tick_div=0 SHALL yield a tick every cycle.
REQ-008 In RAMP, on each tick, duty SHALL move toward target:
- up: target-duty <= step ? target : duty+step
- down: duty-target <= step ? target : duty-step
- comparison unsigned, DW+1 bits; no overshoot, no wrap
REQ-009 In RAMP, on the tick where the new duty equals target, SHALL go RAMP->HOLD with hold counter 0. target equal to duty at acceptance SHALL cost exactly one tick in RAMP.
REQ-010 In HOLD, on each tick:
- hold counter == latched hold: pulse done for one cycle, go HOLD->IDLE
- otherwise: increment hold counter
- hold=0 completes on the first HOLD tick
REQ-011 abort=1 in RAMP or HOLD SHALL force IDLE on the next edge, leave duty at its present value, and not pulse done. abort in IDLE SHALL have no effect. abort with cmd_valid SHALL win, with no acceptance.
REQ-012 ena=0 SHALL hold state, duty, prescaler and counters, force cmd_ready=0, and keep done=0.
REQ-013 tick_div SHALL be sampled live; changing it mid-fade takes effect on the next prescaler comparison.
REQ-014 done SHALL never be high for two consecutive cycles.

Reset
REQ-015 rst_n=1 on a clk edge SHALL set state IDLE, duty 0, done 0, prescaler 0, hold counter 0, and latched target/step/hold 0, regardless of ena or current state.
REQ-016 Reset mid-fade SHALL abandon the command with no done pulse; cmd_ready SHALL be high on the first cycle after reset deasserts, given ena=1 and abort=0.

Verification
REQ-017 Up-ramp:
- stimulus: duty 0, tick_div 0, target 10, step 4, hold 0
- response: duty 4, 8, 10 on the three edges after acceptance; done high for one cycle on the next edge; then IDLE with cmd_ready=1
REQ-018 Down-ramp with prescaler and hold:
- stimulus: duty 200, tick_div 2, target 190, step 7, hold 2
- response: duty 193 then 190, each change 3 cycles apart; 3 HOLD ticks; done once; busy=1 throughout until the done edge
REQ-019 Saturation and zero step:
- stimulus 1: duty 250, target 255, step 15
- response 1: duty 255 in one tick, no wrap
- stimulus 2: step 0
- response 2: behaves as step 1
REQ-020 Abort:
- stimulus: abort during RAMP at duty 8
- response: IDLE next edge, duty stays 8, done never asserted
- stimulus: abort with cmd_valid in IDLE
- response: no acceptance
REQ-021 ena and reset:
- stimulus: ena=0 for 5 cycles mid-RAMP
- response: duty and state frozen; resumes identically afterward
- stimulus: rst_n=1 in HOLD
- response: duty 0, IDLE, done 0 on the next edge
REQ-022 Same-target command:
- stimulus: target equal to current duty, hold 0, tick_div 0
- response: done on the second edge after acceptance; duty never changes
